clkdiv_ctrl: RTL and testbench

Run-time controller for the team's clock-divider datapath. It holds a programmable half-period count and accepts new ratios over a valid/ready handshake. It produces a 50%-duty `div_clk` plus a one-cycle `tick` enable, and starts, stops and re-ratios the divider only at full-period boundaries, so `div_clk` never glitches or emits a runt pulse. It sits between a configuration master and every block that consumes the divided clock enable.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_ctrl_if.sv | 24 ++
 rtl/clkdiv_counter.sv | 28 ++
 rtl/clkdiv_ctrl.sv | 87 ++++++++
 tb/tb_clkdiv_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and defaults for the clock-divider controller
package clkdiv_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 50;

  typedef enum logic [1:0] {
    STATE_STOP = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_PEND = 2'd2
  } clkdiv_state_e;

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// rtl/clkdiv_ctrl_if.sv - ratio configuration handshake between master and divider controller
interface clkdiv_ctrl_if
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;

  modport master (
    output div_in,
    output div_valid,
    input  div_ready
  );

  modport slave (
    input  div_in,
    input  div_valid,
    output div_ready
  );

endinterface

// File: rtl/clkdiv_counter.sv
// rtl/clkdiv_counter.sv - half-period counter with clear, enable and terminal flag
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] count;

  // limit is never 0, so limit-1 cannot underflow
  assign term = (count == (limit - 1'b1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - run-time divider controller: glitch-free start, stop and re-ratio
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  clkdiv_ctrl_if.slave     cfg,
  output logic             div_clk,
  output logic             tick,
  output logic             active,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [1:0] STOP = STATE_STOP;
  localparam logic [1:0] RUN  = STATE_RUN;
  localparam logic [1:0] PEND = STATE_PEND;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] req_div;
  logic             xfer;
  logic             term;
  logic             toggle;
  logic             fall;

  assign cfg.div_ready = (state != PEND);
  assign xfer          = cfg.div_valid && cfg.div_ready;
  assign req_div       = (cfg.div_in == '0) ? DIV_ONE : cfg.div_in;
  assign toggle        = (state != STOP) && term;
  assign fall          = toggle && div_clk;
  assign active        = (state != STOP);

  clkdiv_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state == STOP),
    .en    (state != STOP),
    .limit (cur_div),
    .term  (term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= STOP;
      div_clk  <= 1'b0;
      tick     <= 1'b0;
      cur_div  <= DIV_RST;
      pend_div <= '0;
    end else begin
      tick    <= toggle;
      div_clk <= div_clk ^ toggle;
      case (state)
        STOP: begin
          if (xfer) cur_div <= req_div;
          if (en)   state   <= RUN;
        end
        RUN: begin
          // a ratio arriving on the stopping edge is applied directly, counter restarts at 0
          if (fall && !en) begin
            state <= STOP;
            if (xfer) cur_div <= req_div;
          end else if (xfer) begin
            pend_div <= req_div;
            state    <= PEND;
          end
        end
        PEND: begin
          if (fall) begin
            cur_div <= pend_div;
            state   <= en ? RUN : STOP;
          end
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - self-checking bench for clkdiv_ctrl with CNT_W=8, DEFAULT_DIV=3
module tb_clkdiv_ctrl;
  import clkdiv_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       div_clk;
  logic       tick;
  logic       active;
  logic [7:0] cur_div;

  int vectors    = 0;
  int miscompares = 0;

  clkdiv_ctrl_if #(.CNT_W(8)) cfg_if ();

  clkdiv_ctrl #(
    .CNT_W       (8),
    .DEFAULT_DIV (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .cfg     (cfg_if),
    .div_clk (div_clk),
    .tick    (tick),
    .active  (active),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference: position within the full period 0..2N-1, div_clk high in the second half
  bit m_run, m_pv, m_dc, m_tick;
  int m_n, m_pn, m_ph;

  task automatic model_step();
    bit rdy, xf, fall;
    int nv, nph;
    rdy = !(m_run && m_pv);
    xf  = cfg_if.div_valid && rdy;
    nv  = (cfg_if.div_in == 8'd0) ? 1 : int'(cfg_if.div_in);
    if (reset) begin
      m_run = 0; m_pv = 0; m_n = 3; m_pn = 0; m_ph = 0; m_dc = 0; m_tick = 0;
    end else if (!m_run) begin
      if (xf) m_n = nv;
      if (en) begin m_run = 1; m_ph = 0; end
      m_dc = 0; m_tick = 0;
    end else begin
      nph    = (m_ph + 1) % (2 * m_n);
      fall   = (nph == 0);
      m_tick = ((nph >= m_n) != m_dc);
      m_dc   = (nph >= m_n);
      if (fall) begin
        if (m_pv) begin
          m_n = m_pn; m_pv = 0;
        end else if (xf) begin
          if (!en) m_n = nv;
          else begin m_pn = nv; m_pv = 1; end
        end
        if (!en) m_run = 0;
      end else if (xf) begin
        m_pn = nv; m_pv = 1;
      end
      m_ph = nph;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [11:0] got, want;
    model_step();
    @(posedge clk);
    @(negedge clk);
    got  = {div_clk, tick, active, cfg_if.div_ready, cur_div};
    want = {m_dc, m_tick, m_run, !(m_run && m_pv), 8'(m_n)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL model {clk,tick,act,rdy,cur}: got %h want %h at %0t", got, want, $time);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit       dc;
    bit       tk;
    bit       act;
    bit [7:0] cur;
    bit       rdy;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mkv(bit rst, bit e, bit dc, bit tk, bit act, bit [7:0] cur, bit rdy);
    vec_t v;
    v.rst = rst; v.en = e; v.dc = dc; v.tk = tk; v.act = act; v.cur = cur; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    en    = 1'b0;
    cfg_if.div_valid = 1'b0;
    cfg_if.div_in    = 8'd0;
    m_run = 0; m_pv = 0; m_n = 3; m_pn = 0; m_ph = 0; m_dc = 0; m_tick = 0;
    @(negedge clk);

    // reset then enable: first rise 3 edges after en, period 6
    tbl[0]  = mkv(1, 0, 0, 0, 0, 3, 1);
    tbl[1]  = mkv(0, 1, 0, 0, 1, 3, 1);
    tbl[2]  = mkv(0, 1, 0, 0, 1, 3, 1);
    tbl[3]  = mkv(0, 1, 0, 0, 1, 3, 1);
    tbl[4]  = mkv(0, 1, 1, 1, 1, 3, 1);
    tbl[5]  = mkv(0, 1, 1, 0, 1, 3, 1);
    tbl[6]  = mkv(0, 1, 1, 0, 1, 3, 1);
    tbl[7]  = mkv(0, 1, 0, 1, 1, 3, 1);
    tbl[8]  = mkv(0, 1, 0, 0, 1, 3, 1);
    tbl[9]  = mkv(0, 1, 0, 0, 1, 3, 1);
    tbl[10] = mkv(0, 1, 1, 1, 1, 3, 1);
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst;
      en    = tbl[i].en;
      cycle();
      chk($sformatf("tbl%0d", i),
          int'({div_clk, tick, active, cur_div, cfg_if.div_ready}),
          int'({tbl[i].dc, tbl[i].tk, tbl[i].act, tbl[i].cur, tbl[i].rdy}));
    end

    // mid-run change 3 -> 5 right after a rising toggle
    cfg_if.div_valid = 1; cfg_if.div_in = 8'd5;
    cycle();
    cfg_if.div_valid = 0;
    chk("mid_ready_low", cfg_if.div_ready, 0);
    cycle();
    chk("mid_ready_low2", cfg_if.div_ready, 0);
    chk("mid_cur_old", cur_div, 3);
    cycle();
    chk("mid_fall", div_clk, 0);
    chk("mid_cur_new", cur_div, 5);
    chk("mid_ready_back", cfg_if.div_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mid_low5", div_clk, 0);
    end
    cycle();
    chk("mid_rise5", {div_clk, tick}, 2'b11);

    // graceful stop while high: high phase completes, no runt
    en = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stop_hold_high", {div_clk, active}, 2'b11);
    end
    cycle();
    chk("stop_fall", {div_clk, active}, 2'b00);
    cycle();
    chk("stop_quiet", {div_clk, tick, active}, 3'b000);

    // config N=1 in STOP, then run at clk/2
    cfg_if.div_valid = 1; cfg_if.div_in = 8'd1;
    cycle();
    cfg_if.div_valid = 0;
    chk("stop_cfg_cur", cur_div, 1);
    chk("stop_cfg_inactive", active, 0);
    en = 1;
    cycle();
    chk("n1_start", {div_clk, tick, active}, 3'b001);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("n1_tick", tick, 1);
      chk("n1_clk", div_clk, (i % 2 == 0) ? 1 : 0);
    end

    // back to N=3, then stop during a 3-cycle high phase
    cfg_if.div_valid = 1; cfg_if.div_in = 8'd3;
    cycle();
    cfg_if.div_valid = 0;
    chk("n3_pend", {cfg_if.div_ready, div_clk}, 2'b01);
    cycle();
    chk("n3_apply", {div_clk, tick, cfg_if.div_ready}, 3'b011);
    chk("n3_cur", cur_div, 3);
    cycle(); cycle();
    chk("n3_low", div_clk, 0);
    cycle();
    chk("n3_rise", {div_clk, tick}, 2'b11);
    en = 0;
    cycle(); cycle();
    chk("n3_high3", {div_clk, tick, active}, 3'b101);
    cycle();
    chk("n3_stopped", {div_clk, active}, 2'b00);

    // zero clamp: refused in PEND, accepted in RUN with en dropped
    en = 1;
    cycle();
    cfg_if.div_valid = 1; cfg_if.div_in = 8'd7;
    cycle();
    chk("zc_pend", cfg_if.div_ready, 0);
    cfg_if.div_in = 8'd0;
    cycle();
    chk("zc_refused_rdy", cfg_if.div_ready, 0);
    chk("zc_refused_cur", cur_div, 3);
    n = 0;
    while (cfg_if.div_ready !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("zc_release_in_time", (n < 20) ? 1 : 0, 1);
    chk("zc_loaded_7", cur_div, 7);
    en = 0;
    cycle();
    cfg_if.div_valid = 0;
    chk("zc_accept_run", cfg_if.div_ready, 0);
    n = 0;
    while (active !== 1'b0 && n < 40) begin cycle(); n++; end
    chk("zc_stop_in_time", (n < 40) ? 1 : 0, 1);
    chk("zc_clamped", cur_div, 1);
    chk("zc_clk_low", div_clk, 0);
    cycle();
    chk("zc_stays_stop", active, 0);

    // reset while PEND holds 7
    en = 1;
    cycle();
    cfg_if.div_valid = 1; cfg_if.div_in = 8'd7;
    cycle();
    cfg_if.div_valid = 0;
    chk("rp_pend", cfg_if.div_ready, 0);
    reset = 1;
    cycle();
    reset = 0;
    chk("rp_reset", {div_clk, tick, active, cfg_if.div_ready}, 4'b0001);
    chk("rp_cur", cur_div, 3);
    for (int i = 0; i < 14; i++) cycle();
    chk("rp_discarded", cur_div, 3);

    // randomized traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) en = ~en;
      cfg_if.div_valid = ($urandom_range(0, 3) == 0);
      cfg_if.div_in    = 8'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
